// File: rtl/step_sched_pkg.sv
// Shared definitions for the elimination-line sequencer: FSM encoding and the
// helpers that derive block/phase counts from the matrix and line geometry.
package step_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ADV   = 3'd3,
    ST_END   = 3'd4
  } state_e;

  function automatic int clog2_f(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  // NB: column blocks per row of blocks
  function automatic int nb_f(input int k, input int n);
    return k / n;
  endfunction

  // NP: elimination phases, ceil(L/N)
  function automatic int np_f(input int l, input int n);
    return (l + n - 1) / n;
  endfunction

  // DELAY: pipeline depth of the attached step line
  function automatic int delay_f(input int n, input int block);
    return (n - 1) / block + 1;
  endfunction

endpackage

// File: rtl/step_sched_watchdog.sv
// Loadable down-counter; expire_o flags the last enabled cycle of the window.
module step_sched_watchdog #(
  parameter int W    = 6,
  parameter int LOAD = 63
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= W'(LOAD);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/step_sched.sv
// Sequencer for the systolic elimination line: one pivot pass and the trailing
// apply passes per phase, with fail / watchdog / host-abort termination.
//
// state | meaning
// IDLE  | waiting for go
// ISSUE | pass coordinates ready, held off by hold
// WAIT  | pass in flight, watchdog running
// ADV   | pick next pass or finish; issues directly when hold is low
// END   | done pulse cycle, busy already low
module step_sched
  import step_sched_pkg::*;
#(
  parameter int N     = 4,
  parameter int L     = 8,
  parameter int K     = 16,
  parameter int BLOCK = 4,
  parameter int TMO   = 64
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         go_i,
  input  logic                                         abort_i,
  input  logic                                         hold_i,
  output logic                                         busy_o,
  output logic                                         done_o,
  output logic                                         fail_o,
  output logic                                         timeout_o,
  output logic [clog2_f(np_f(L, N) + 1)-1:0]           phase_o,
  output logic                                         step_start_o,
  output logic                                         step_functionA_o,
  output logic                                         step_last_phase_o,
  output logic [clog2_f(nb_f(K, N) + 1)-1:0]           step_col_block_o,
  output logic [clog2_f(L * K / N + 2 * N + 1)-1:0]    step_first_pass_rows_o,
  input  logic                                         step_done_i,
  input  logic                                         step_fail_i
);

  localparam int NB_C    = nb_f(K, N);
  localparam int NP_C    = np_f(L, N);
  localparam int DLY_C   = delay_f(N, BLOCK);
  // A watchdog shorter than one full pass would fire on healthy hardware
  localparam int TMO_MIN = L + 2 * N + DLY_C + 5;
  localparam int TMO_EFF = (TMO >= TMO_MIN) ? TMO : TMO_MIN;
  localparam int PH_W    = clog2_f(NP_C + 1);
  localparam int CB_W    = clog2_f(NB_C + 1);
  localparam int FPR_W   = clog2_f(L * K / N + 2 * N + 1);
  localparam int WD_W    = clog2_f(TMO_EFF);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(NP_C - 1);
  localparam logic [CB_W-1:0] CB_LAST = CB_W'(NB_C - 1);

  state_e            state_q;
  logic [PH_W-1:0]   phase_q;
  logic [CB_W-1:0]   blk_q;
  logic              busy_q, done_q, fail_q, timeout_q, abort_q;
  logic              start_q, fn_a_q, last_q;
  logic [CB_W-1:0]   col_q;
  logic [FPR_W-1:0]  rows_q;

  logic [PH_W-1:0]   iss_phase;
  logic [CB_W-1:0]   iss_blk;
  logic [FPR_W-1:0]  iss_rows;
  logic              iss_pivot, adv_more, stop_req, issue_now, wd_expire;

  always_comb begin
    iss_phase = phase_q;
    iss_blk   = blk_q;
    adv_more  = 1'b0;
    if (state_q == ST_ADV) begin
      if (blk_q < CB_LAST) begin
        iss_blk  = blk_q + 1'b1;
        adv_more = 1'b1;
      end else if (phase_q < PH_LAST) begin
        iss_phase = phase_q + 1'b1;
        iss_blk   = CB_W'(phase_q) + 1'b1;
        adv_more  = 1'b1;
      end
    end
    iss_pivot = (iss_blk == CB_W'(iss_phase));
    iss_rows  = FPR_W'(iss_phase) * FPR_W'(L) + FPR_W'(iss_phase) * FPR_W'(N);
  end

  assign stop_req  = abort_q || fail_q || timeout_q;
  assign issue_now = !hold_i &&
                     ((state_q == ST_ISSUE) ||
                      ((state_q == ST_ADV) && !stop_req && adv_more));

  step_sched_watchdog #(
    .W    (WD_W),
    .LOAD (TMO_EFF - 1)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (issue_now),
    .en_i     (state_q == ST_WAIT),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      blk_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      abort_q   <= 1'b0;
      start_q   <= 1'b0;
      fn_a_q    <= 1'b0;
      last_q    <= 1'b0;
      col_q     <= '0;
      rows_q    <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      if ((state_q != ST_IDLE) && abort_i) abort_q <= 1'b1;

      if (issue_now) begin
        start_q <= 1'b1;
        fn_a_q  <= iss_pivot;
        col_q   <= iss_blk;
        last_q  <= (iss_phase == PH_LAST);
        rows_q  <= iss_pivot ? iss_rows : '0;
        phase_q <= iss_phase;
        blk_q   <= iss_blk;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (go_i) begin
            phase_q   <= '0;
            blk_q     <= '0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            abort_q   <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issue_now) state_q <= ST_WAIT;
        end
        // fail and timeout also pass through ADV so every ending sees done 2 cycles later
        ST_WAIT: begin
          if (step_done_i) begin
            if (step_fail_i && fn_a_q) fail_q <= 1'b1;
            state_q <= ST_ADV;
          end else if (wd_expire) begin
            timeout_q <= 1'b1;
            state_q   <= ST_ADV;
          end
        end
        ST_ADV: begin
          if (stop_req || !adv_more) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_END;
          end else if (issue_now) begin
            state_q <= ST_WAIT;
          end else begin
            phase_q <= iss_phase;
            blk_q   <= iss_blk;
            state_q <= ST_ISSUE;
          end
        end
        ST_END: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o                 = busy_q;
  assign done_o                 = done_q;
  assign fail_o                 = fail_q;
  assign timeout_o              = timeout_q;
  assign phase_o                = phase_q;
  assign step_start_o           = start_q;
  assign step_functionA_o       = fn_a_q;
  assign step_last_phase_o      = last_q;
  assign step_col_block_o       = col_q;
  assign step_first_pass_rows_o = rows_q;

endmodule

// File: tb/tb_step_sched.sv
// Self-checking bench for step_sched: directed scenario table, randomized
// scenarios against a pass-list model, and a mid-sequence reset sequence.
module tb_step_sched;

  localparam int N = 4, L = 8, K = 16, BLOCK = 4, TMO = 64;
  localparam int NB = K / N;
  localparam int NP = (L + N - 1) / N;
  localparam int PH_W = $clog2(NP + 1);
  localparam int CB_W = $clog2(NB + 1);
  localparam int FPR_W = $clog2(L * K / N + 2 * N + 1);

  logic clk = 1'b0;
  logic rst = 1'b1, go = 1'b0, abort_r = 1'b0, hold = 1'b0;
  logic step_done = 1'b0, step_fail = 1'b0;
  logic busy, done, fail, timeout, step_start, step_fa, step_last;
  logic [PH_W-1:0]  phase;
  logic [CB_W-1:0]  step_col;
  logic [FPR_W-1:0] step_rows;

  step_sched #(.N(N), .L(L), .K(K), .BLOCK(BLOCK), .TMO(TMO)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .go_i                   (go),
    .abort_i                (abort_r),
    .hold_i                 (hold),
    .busy_o                 (busy),
    .done_o                 (done),
    .fail_o                 (fail),
    .timeout_o              (timeout),
    .phase_o                (phase),
    .step_start_o           (step_start),
    .step_functionA_o       (step_fa),
    .step_last_phase_o      (step_last),
    .step_col_block_o       (step_col),
    .step_first_pass_rows_o (step_rows),
    .step_done_i            (step_done),
    .step_fail_i            (step_fail)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference pass list: per phase one pivot pass then every later column block
  int  npass;
  bit  ex_fa[32];
  int  ex_blk[32], ex_ph[32], ex_rows[32];
  bit  ex_last[32];

  task automatic build_model();
    npass = 0;
    for (int p = 0; p < NP; p++) begin
      for (int b = p; b < NB; b++) begin
        ex_fa[npass]   = (b == p);
        ex_blk[npass]  = b;
        ex_ph[npass]   = p;
        ex_last[npass] = (p == NP - 1);
        ex_rows[npass] = (b == p) ? (p * L + p * N) : 0;
        npass++;
      end
    end
  endtask

  function automatic int model_end(input int fail_p, input int wh_p, input int ab_p,
                                   output bit efail, output bit etmo);
    efail = 1'b0;
    etmo  = 1'b0;
    for (int i = 0; i < npass; i++) begin
      if (i == wh_p) begin etmo = 1'b1; return i + 1; end
      if ((i == fail_p) && ex_fa[i]) begin efail = 1'b1; return i + 1; end
      if (i == ab_p) return i + 1;
    end
    return npass;
  endfunction

  task automatic run_scn(input string nm, input int fail_p, input int wh_p, input int ab_p,
                         input int hold_p, input int hold_len, input int dly,
                         input int exp_n, input bit exp_fail, input bit exp_tmo,
                         input bit go_spam);
    int n_st = 0, c0, t_sd = -1, t_ab = -1, t_go2 = -1, h_lo = -1, h_hi = -1;
    int last_sd = -1, last_start = -1, exp_start, t_dn = -1, n_dn = 0, exp_done;
    @(negedge clk);
    go = 1'b1;
    c0 = cyc;
    @(negedge clk);
    go = 1'b0;
    chk({nm, " busy after go"}, busy, 1);
    chk({nm, " fail cleared by go"}, fail, 0);
    exp_start = c0 + 2;
    for (int it = 0; it < 3000; it++) begin
      if (step_start) begin
        if (n_st < npass) begin
          chk($sformatf("%s p%0d start cycle", nm, n_st), cyc, exp_start);
          chk($sformatf("%s p%0d functionA", nm, n_st), step_fa, ex_fa[n_st]);
          chk($sformatf("%s p%0d col_block", nm, n_st), step_col, ex_blk[n_st]);
          chk($sformatf("%s p%0d last_phase", nm, n_st), step_last, ex_last[n_st]);
          chk($sformatf("%s p%0d first_rows", nm, n_st), step_rows, ex_rows[n_st]);
          chk($sformatf("%s p%0d phase", nm, n_st), phase, ex_ph[n_st]);
        end
        n_st++;
        last_start = cyc;
        t_sd = (n_st - 1 == wh_p) ? -1 : cyc + dly;
        if (n_st - 1 == ab_p) t_ab = cyc + 3;
        if (go_spam && n_st == 2) t_go2 = cyc + 5;
      end
      if (done) begin
        n_dn++;
        if (t_dn < 0) begin
          t_dn = cyc;
          chk({nm, " busy low with done"}, busy, 0);
        end
      end
      step_done = (cyc == t_sd);
      step_fail = step_done ? (n_st - 1 == fail_p) : 1'($urandom_range(0, 1));
      if (step_done) begin
        last_sd   = cyc;
        exp_start = cyc + 2 + ((n_st == hold_p) ? hold_len : 0);
        if (n_st == hold_p) begin
          h_lo = cyc + 1;
          h_hi = cyc + hold_len;
        end
      end
      hold    = (cyc >= h_lo) && (cyc <= h_hi);
      abort_r = (cyc == t_ab);
      go      = (cyc == t_go2);
      if ((t_dn >= 0) && (cyc >= t_dn + 4)) break;
      @(negedge clk);
    end
    step_done = 1'b0;
    step_fail = 1'b0;
    hold      = 1'b0;
    abort_r   = 1'b0;
    go        = 1'b0;
    exp_done  = exp_tmo ? last_start + TMO + 1 : last_sd + 2;
    chk({nm, " done seen"}, int'(t_dn >= 0), 1);
    chk({nm, " passes issued"}, n_st, exp_n);
    chk({nm, " done pulses"}, n_dn, 1);
    chk({nm, " done cycle"}, t_dn, exp_done);
    chk({nm, " fail flag"}, fail, exp_fail);
    chk({nm, " timeout flag"}, timeout, exp_tmo);
    chk({nm, " busy after end"}, busy, 0);
  endtask

  task automatic wait_start(input string nm, output int t);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (step_start) begin
        t = cyc;
        break;
      end
    end
    chk({nm, " start seen"}, int'(t >= 0), 1);
  endtask

  typedef struct {
    string nm;
    int    fail_p, wh_p, ab_p, hold_p, hold_len, dly;
    int    exp_n;
    bit    exp_fail, exp_tmo;
  } scn_t;

  scn_t tbl[6];

  initial begin
    int  ts;
    int  fp, wp, ap, hp, hl, dl, en;
    bit  ef, et;

    tbl[0] = '{"nominal",     -1, -1, -1, -1,  0, 22, 7, 1'b0, 1'b0};
    tbl[1] = '{"fail_pivot2",  4, -1, -1, -1,  0, 22, 5, 1'b1, 1'b0};
    tbl[2] = '{"fail_apply",   2, -1, -1, -1,  0, 22, 7, 1'b0, 1'b0};
    tbl[3] = '{"withhold",    -1,  0, -1, -1,  0, 22, 1, 1'b0, 1'b1};
    tbl[4] = '{"abort_pass2", -1, -1,  1, -1,  0, 22, 2, 1'b0, 1'b0};
    tbl[5] = '{"hold_pass4",  -1, -1, -1,  3, 10, 22, 7, 1'b0, 1'b0};

    build_model();

    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset start", step_start, 0);
    chk("reset rows", step_rows, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle busy", busy, 0);

    // abort while idle must not leak into the next sequence
    abort_r = 1'b1;
    @(negedge clk);
    abort_r = 1'b0;

    foreach (tbl[i])
      run_scn(tbl[i].nm, tbl[i].fail_p, tbl[i].wh_p, tbl[i].ab_p, tbl[i].hold_p,
              tbl[i].hold_len, tbl[i].dly, tbl[i].exp_n, tbl[i].exp_fail, tbl[i].exp_tmo,
              1'b1);

    for (int r = 0; r < 10; r++) begin
      fp = int'($urandom_range(0, 9)) - 1;
      wp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
      ap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1;
      hp = int'($urandom_range(1, 6));
      hl = int'($urandom_range(0, 12));
      dl = int'($urandom_range(5, 40));
      en = model_end(fp, wp, ap, ef, et);
      run_scn($sformatf("rnd%0d", r), fp, wp, ap, hp, hl, dl, en, ef, et, r[0]);
    end

    // reset while the second pass is in flight
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_start("rst_seq p0", ts);
    repeat (3) @(negedge clk);
    step_done = 1'b1;
    @(negedge clk);
    step_done = 1'b0;
    wait_start("rst_seq p1", ts);
    repeat (3) @(negedge clk);
    chk("rst_seq busy before", busy, 1);
    chk("rst_seq col before", step_col, 1);
    rst = 1'b1;
    #1;
    chk("rst_seq busy", busy, 0);
    chk("rst_seq col", step_col, 0);
    chk("rst_seq functionA", step_fa, 0);
    chk("rst_seq phase", phase, 0);
    chk("rst_seq last", step_last, 0);
    chk("rst_seq start", step_start, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_scn("after_rst", -1, -1, -1, -1, 0, 22, 7, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global time limit: got cycle %0d expected completion", cyc);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/step_sched.md
# step_sched

Sequencer for the systolic elimination line (`step`): walks an L×K matrix through all elimination phases. For each phase it issues one functionA (pivot) pass on the pivot column block and one functionB (apply) pass on every later column block. It drives the `step` control inputs, waits for each pass to complete, and aborts on a singular pivot block, a watchdog timeout or a host abort. It sits between the host/top-level control and a single `step` instance.

## Interface
- `N`, 4: systolic line width; must match `step`.
- `L`, 8: matrix rows.
- `K`, 16: matrix columns; K % N == 0, ceil(L/N) <= K/N.
- `BLOCK`, 4: `step` pipeline block size; used only to derive DELAY = (N-1)/BLOCK + 1.
- `TMO`, 64: watchdog limit in cycles per pass; must exceed L + 2N + DELAY + 4.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `go` in 1: one-cycle request to start a full elimination; ignored unless idle.
- `abort` in 1: request to stop after the pass in flight.
- `hold` in 1: defers issue of the next pass while high.
- `busy` out 1: high from the cycle after an accepted `go` until `done`.
- `done` out 1: one-cycle pulse when the sequence ends, whether it completes, fails or aborts.
- `fail` out 1: sticky; set when a functionA pass reports fail; cleared on accepted `go`.
- `timeout` out 1: sticky; set when the watchdog expires; cleared on accepted `go`.
- `phase` out CLOG2(ceil(L/N)+1): current phase index.
- `step_start` out 1: one-cycle start pulse to `step`.
- `step_functionA` out 1: pass type; 1 = pivot pass, 0 = apply pass.
- `step_last_phase` out 1: high during phase NP-1.
- `step_col_block` out CLOG2(K/N+1): column block for the current pass.
- `step_first_pass_rows` out CLOG2(L*K/N+2N+1): first-pass row bound for the current pass.
- `step_done` in 1: pass complete, one-cycle pulse from `step`.
- `step_fail` in 1: singular flag from `step`; sampled only with `step_done`.

## Operation
- Derived constants: NB = K/N column blocks; NP = ceil(L/N) phases.
- FSM states: IDLE, ISSUE, WAIT, ADV, END.
- IDLE:
  - on `go`, clear `phase`, `blk`, `fail`, `timeout` and the abort latch;
  - set `busy`; go to ISSUE.
- ISSUE:
  - if `hold`, stay in ISSUE;
  - otherwise pulse `step_start` for 1 cycle and go to WAIT;
  - `step_functionA`, `step_col_block`, `step_last_phase` and `step_first_pass_rows` are registered outputs, valid from the `step_start` cycle and held stable until the next ISSUE.
- Pass fields:
  - pivot pass: `blk == phase`, `step_functionA = 1`;
  - apply pass: `blk` runs from phase+1 to NB-1, `step_functionA = 0`;
  - `step_col_block = blk`;
  - `step_last_phase = (phase == NP-1)`;
  - `step_first_pass_rows = phase*L + phase*N` for pivot passes, 0 for apply passes. Compute at full output width with no truncation.
- WAIT:
  - watchdog counts from 0 at `step_start`;
  - on `step_done`, go to ADV;
  - if `step_done && step_fail && step_functionA`, set `fail` and go to END;
  - if the watchdog reaches TMO-1 without `step_done`, set `timeout` and go to END.
- ADV:
  - if the abort latch is set, go to END;
  - else if `blk < NB-1`, increment `blk` and go to ISSUE;
  - else if `phase < NP-1`, increment `phase`, set `blk = phase+1` (the new phase index), and go to ISSUE;
  - else go to END.
- END: pulse `done` for 1 cycle, clear `busy`, return to IDLE.
- `abort`:
  - a pulse in any non-IDLE state sets the abort latch;
  - a pass already issued is never cut short;
  - `abort` in IDLE is ignored.
- `step_fail` on an apply pass is ignored.
- `go` while busy is ignored.

## Timing
- Reset values: `busy` = 0, `done` = 0, `fail` = 0, `timeout` = 0, `step_start` = 0, `step_functionA` = 0, `step_last_phase` = 0, `step_col_block` = 0, `step_first_pass_rows` = 0, `phase` = 0; FSM in IDLE; watchdog and abort latch cleared.
- `go` in cycle t: `busy` = 1 at t+1; first `step_start` at t+2 when `hold` is low.
- `step_done` in cycle t: next `step_start` at t+2 (WAIT→ADV→ISSUE). This gap also covers `step`'s internal 3-cycle start pipeline, so `step_done` never overlaps `step_start`.
- `done` fires 2 cycles after the final `step_done`, or 2 cycles after the fail/timeout event, and coincides with `busy` falling.
- `rst` mid-sequence: all outputs return to reset values immediately. The attached `step` must be reset by the same `rst`.
- `hold` is sampled only in ISSUE; asserting it in WAIT has no effect on the pass in flight.

## Structure
- A shared package holds:
  - `CLOG2`;
  - FSM state encoding;
  - the derived constants NB, NP and DELAY, shared with the top level that instantiates `step`.
- One natural sub-module: `step_watchdog`, a loadable down-counter with `expire` output, reused for the per-pass timeout.

## Test plan
- N=4, L=8, K=16, `go` once with `step_done` returned 22 cycles after each start:
  - 7 passes in the order (A,0), (B,1), (B,2), (B,3), (A,1), (B,2), (B,3);
  - `step_last_phase` = 1 only on the last 3 passes;
  - pivot-pass `step_first_pass_rows` = 0, then 12;
  - one `done` pulse; `fail` = 0.
- `step_fail` = 1 with `step_done` on the second pivot pass: no further `step_start`; `done` 2 cycles later; `fail` = 1. A subsequent `go` clears `fail`.
- `step_fail` = 1 on an apply pass: ignored; full 7-pass sequence completes.
- `step_done` withheld with TMO=64: `timeout` = 1 and `done` pulse at cycle 64 + 1 after `step_start`.
- `abort` pulsed mid-pass 2: pass 2 completes; no pass 3 issued; `done` = 1; `fail` = 0.
- `hold` high for 10 cycles before pass 4: `step_start` delayed exactly 10 cycles. Separately, `rst` asserted during WAIT: all outputs reach reset values immediately, and `go` after `rst` restarts from (A,0).
